// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: shared state encoding, mode constants and sampling points for the serial receiver.
package serial_rx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_M0_SHIFT, S_START, S_DATA, S_STOP} state_e;
  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_A = 4'd7;
  localparam logic [3:0] SAMPLE_B = 4'd8;
  localparam logic [3:0] SAMPLE_C = 4'd9;
  localparam logic [3:0] BITS_M0 = 4'd8;
  localparam logic [3:0] BITS_M1 = 4'd8;
  localparam logic [3:0] BITS_M23 = 4'd9;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/serial_rx_sync_edge.sv
// serial_rx_sync_edge: RXD metastability synchronizer plus falling-edge detector.
module serial_rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic serial_clock_i,
  input  logic serial_reset_i_b,
  input  logic rxd_i,
  output logic rxd_sync_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  // Flops reset to 1 so an idle line never looks like a start edge after reset.
  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign rxd_sync_o = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~rxd_sync_o;
endmodule

// File: rtl/serial_rx.sv
// serial_rx: 8051-style serial receive path, mode 0 shift register and modes 1-3 oversampled UART.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_br_i,
  input  logic       serial_rxd_i,
  input  logic       serial_scon7_sm0_i,
  input  logic       serial_scon6_sm1_i,
  input  logic       serial_scon5_sm2_i,
  input  logic       serial_scon4_ren_i,
  input  logic       serial_scon0_ri_i,
  output logic [7:0] serial_data_sbuf_o,
  output logic       serial_scon2_rb8_o,
  output logic       serial_scon0_ri_set_o,
  output logic       serial_shift_clk_o,
  output logic       serial_txd_en_o
);
  logic rxd_s, rxd_fall;
  state_e state_q, state_d;
  logic [3:0] sample_cnt_q, sample_cnt_d, bit_cnt_q, bit_cnt_d, cnt_inc, nbits;
  logic [7:0] shreg_q, shreg_d, sbuf_q, sbuf_d;
  logic [1:0] mode_q, mode_d, mode;
  logic bit9_q, bit9_d, samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic rb8_q, rb8_d, ri_set_q, ri_set_d, shift_clk_q, shift_clk_d, txd_en_q, txd_en_d;
  logic maj, bitx;

  serial_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .serial_clock_i  (serial_clock_i),
    .serial_reset_i_b(serial_reset_i_b),
    .rxd_i           (serial_rxd_i),
    .rxd_sync_o      (rxd_s),
    .fall_o          (rxd_fall)
  );

  assign mode = {serial_scon7_sm0_i, serial_scon6_sm1_i};
  assign cnt_inc = sample_cnt_q + 4'd1;
  assign maj = maj3(samp_a_q, samp_b_q, rxd_s);
  assign nbits = (mode_q == MODE1) ? BITS_M1 : BITS_M23;
  assign bitx = (mode_q == MODE1) ? maj : bit9_q;

  always_comb begin
    state_d = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d = shreg_q;
    sbuf_d = sbuf_q;
    mode_d = mode_q;
    bit9_d = bit9_q;
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    rb8_d = rb8_q;
    ri_set_d = 1'b0;
    shift_clk_d = shift_clk_q;
    case (state_q)
      S_IDLE: begin
        shift_clk_d = 1'b1;
        if (serial_scon4_ren_i && mode == MODE0 && !serial_scon0_ri_i) begin
          state_d = S_M0_SHIFT;
          sample_cnt_d = 4'd0;
          bit_cnt_d = 4'd0;
          mode_d = mode;
        end else if (serial_scon4_ren_i && mode != MODE0 && rxd_fall) begin
          state_d = S_START;
          sample_cnt_d = 4'd0;
          bit_cnt_d = 4'd0;
          mode_d = mode;
        end
      end
      S_M0_SHIFT: if (serial_br_i) begin
        sample_cnt_d = cnt_inc;
        shift_clk_d = ~cnt_inc[0];
        if (!cnt_inc[0]) begin
          shreg_d = {rxd_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_d == BITS_M0) begin
            state_d = S_IDLE;
            sbuf_d = shreg_d;
            ri_set_d = 1'b1;
          end
        end
      end
      default: if (serial_br_i) begin
        sample_cnt_d = cnt_inc;
        if (cnt_inc == SAMPLE_A) samp_a_d = rxd_s;
        if (cnt_inc == SAMPLE_B) samp_b_d = rxd_s;
        if (cnt_inc == SAMPLE_C) begin
          if (state_q == S_START && maj) state_d = S_IDLE;
          if (state_q == S_DATA) begin
            if (bit_cnt_q < 4'd8) shreg_d = {maj, shreg_q[7:1]};
            else bit9_d = maj;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (state_q == S_STOP) begin
            state_d = S_IDLE;
            if (!serial_scon0_ri_i && (!serial_scon5_sm2_i || bitx)) begin
              sbuf_d = shreg_q;
              rb8_d = bitx;
              ri_set_d = 1'b1;
            end
          end
        end
        if (cnt_inc == 4'd0) begin
          if (state_q == S_START) begin
            state_d = S_DATA;
            bit_cnt_d = 4'd0;
          end
          if (state_q == S_DATA && bit_cnt_q == nbits) state_d = S_STOP;
        end
      end
    endcase
    // Losing REN or the mode mid-frame abandons the frame without touching SBUF/RB8/RI.
    if (state_q != S_IDLE && (!serial_scon4_ren_i || mode != mode_q)) begin
      state_d = S_IDLE;
      shift_clk_d = 1'b1;
      sbuf_d = sbuf_q;
      rb8_d = rb8_q;
      ri_set_d = 1'b0;
    end
    txd_en_d = state_d == S_M0_SHIFT;
  end

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      state_q <= S_IDLE;
      sample_cnt_q <= 4'd0;
      bit_cnt_q <= 4'd0;
      shreg_q <= 8'h00;
      sbuf_q <= 8'h00;
      mode_q <= MODE0;
      bit9_q <= 1'b0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
      rb8_q <= 1'b0;
      ri_set_q <= 1'b0;
      shift_clk_q <= 1'b1;
      txd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
      sbuf_q <= sbuf_d;
      mode_q <= mode_d;
      bit9_q <= bit9_d;
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
      rb8_q <= rb8_d;
      ri_set_q <= ri_set_d;
      shift_clk_q <= shift_clk_d;
      txd_en_q <= txd_en_d;
    end
  end

  assign serial_data_sbuf_o = sbuf_q;
  assign serial_scon2_rb8_o = rb8_q;
  assign serial_scon0_ri_set_o = ri_set_q;
  assign serial_shift_clk_o = shift_clk_q;
  assign serial_txd_en_o = txd_en_q;
endmodule
